// File: rtl/tcam_cmd_driver_if.sv
// Bundle of the command, TCAM-facing and response signals of tcam_cmd_driver.
//   cmd_*  : valid/ready command stream {write, addr, data, data_x}
//   tcam_* : drive to / result from the level-sensitive TCAM
//   rsp_*  : registered search response with backpressure
// slave  : the driver itself.
// master : the environment, which is the command source, the TCAM and the
//          response consumer.
interface tcam_cmd_driver_if #(
  parameter int N         = 2,
  parameter int WORD_SIZE = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [N-1:0]         cmd_addr;
  logic [WORD_SIZE-1:0] cmd_data;
  logic [WORD_SIZE-1:0] cmd_data_x;

  logic [WORD_SIZE-1:0] tcam_data;
  logic [WORD_SIZE-1:0] tcam_data_x;
  logic                 tcam_w_r_bar;
  logic [N-1:0]         tcam_write_address;
  logic [N-1:0]         tcam_address;
  logic                 tcam_match_flag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [N-1:0]         rsp_address;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_data_x,
    output cmd_ready,
    output tcam_data, tcam_data_x, tcam_w_r_bar, tcam_write_address,
    input  tcam_address, tcam_match_flag,
    output rsp_valid, rsp_hit, rsp_address,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_data_x,
    input  cmd_ready,
    input  tcam_data, tcam_data_x, tcam_w_r_bar, tcam_write_address,
    output tcam_address, tcam_match_flag,
    input  rsp_valid, rsp_hit, rsp_address,
    output rsp_ready
  );
endinterface

// File: rtl/tcam_cmd_driver.sv
// Clocked command front-end for the level-sensitive TCAM.
// Buffers write/search commands in a small FIFO, sequences the TCAM inputs so
// every operation causes an input event, and captures search results into a
// registered response held under backpressure.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : tcam_cmd_driver_if.slave (cmd_*, tcam_*, rsp_*)
//   busy      : FSM not idle or FIFO not empty
//   hit_count : number of hitting searches, saturating at all-ones
module tcam_cmd_driver #(
  parameter int N         = 2,
  parameter int WORD_SIZE = 8,
  parameter int FIFO_LOG2 = 2,
  parameter int SETTLE    = 1,
  parameter int HIT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  tcam_cmd_driver_if.slave   bus,
  output logic               busy,
  output logic [HIT_W-1:0]   hit_count
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef struct packed {
    logic                 wr;
    logic [N-1:0]         addr;
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] x;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WRITE, WREC, SEARCH, RESP} state_t;

  // FIFO: extra pointer MSB tells full from empty.
  cmd_t               mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr, rd_ptr;
  logic               full, empty, push, pop;
  cmd_t               head;

  assign full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                 (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rd_ptr[FIFO_LOG2-1:0]];

  // Storage needs no reset; flushing is done by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_LOG2-1:0]] <= '{wr: bus.cmd_write, addr: bus.cmd_addr,
                                               data: bus.cmd_data, x: bus.cmd_data_x};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + 1'b1;
  end

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WORD_SIZE-1:0] data_q, x_q;
  logic                 wrb_q;
  logic [N-1:0]         waddr_q;
  logic                 rsp_valid_q, rsp_hit_q;
  logic [N-1:0]         rsp_addr_q;
  logic [HIT_W-1:0]     hit_q;

  assign pop = (state == IDLE) && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      cnt         <= '0;
      data_q      <= '0;
      x_q         <= '0;
      wrb_q       <= 1'b0;
      waddr_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_addr_q  <= '0;
      hit_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wrb_q <= 1'b0;
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_q <= head.data;
            x_q    <= head.x;
            if (head.wr) begin
              waddr_q <= head.addr;
              wrb_q   <= 1'b1;
              state   <= WRITE;
            end else begin
              cnt   <= CW'(SETTLE);
              state <= SEARCH;
            end
          end
        end
        WRITE: begin
          // Drop w_r_bar for a cycle so back-to-back writes of the same word
          // still present a fresh edge to the TCAM.
          wrb_q <= 1'b0;
          state <= WREC;
        end
        WREC: state <= IDLE;
        SEARCH: begin
          if (cnt == CW'(1)) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= bus.tcam_match_flag;
            rsp_addr_q  <= bus.tcam_match_flag ? bus.tcam_address : '0;
            if (bus.tcam_match_flag && hit_q != '1) hit_q <= hit_q + 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready          = !full;
  assign bus.tcam_data          = data_q;
  assign bus.tcam_data_x        = x_q;
  assign bus.tcam_w_r_bar       = wrb_q;
  assign bus.tcam_write_address = waddr_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_hit            = rsp_hit_q;
  assign bus.rsp_address        = rsp_addr_q;
  assign busy                   = (state != IDLE) || !empty;
  assign hit_count              = hit_q;

endmodule

// File: tb/tb_tcam_cmd_driver.sv
module tb_tcam_cmd_driver;
  localparam int N     = 2;
  localparam int W     = 8;
  localparam int HIT_W = 2;
  localparam int HMAX  = (1 << HIT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [HIT_W-1:0] hit_count;

  tcam_cmd_driver_if #(.N(N), .WORD_SIZE(W)) bus ();

  tcam_cmd_driver #(.N(N), .WORD_SIZE(W), .FIFO_LOG2(2), .SETTLE(1), .HIT_W(HIT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Behavioural TCAM: stored x bits and key x bits are wildcards, highest
  // matching index wins, address 0 on a miss, no reset of contents.
  logic [W-1:0] e_d [1<<N];
  logic [W-1:0] e_x [1<<N];
  logic         e_v [1<<N];

  initial for (int i = 0; i < (1 << N); i++) begin e_v[i] = 1'b0; e_d[i] = '0; e_x[i] = '0; end

  always @(negedge clk) begin
    if (bus.tcam_w_r_bar) begin
      e_d[bus.tcam_write_address] = bus.tcam_data;
      e_x[bus.tcam_write_address] = bus.tcam_data_x;
      e_v[bus.tcam_write_address] = 1'b1;
    end
  end

  always_comb begin
    bus.tcam_match_flag = 1'b0;
    bus.tcam_address    = '0;
    for (int i = 0; i < (1 << N); i++) begin
      if (e_v[i] && ((~(e_d[i] ^ bus.tcam_data) | e_x[i] | bus.tcam_data_x) == '1)) begin
        bus.tcam_match_flag = 1'b1;
        bus.tcam_address    = N'(i);
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int exp_hits = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic w, input logic [N-1:0] a, input logic [W-1:0] d, input logic [W-1:0] x);
    bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_data_x = x;
  endtask

  // Returns at 1ns after the edge that accepted the command.
  task automatic push(input logic w, input logic [N-1:0] a, input logic [W-1:0] d, input logic [W-1:0] x);
    int t = 0;
    while (!bus.cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.cmd_ready) chk("push_ready_timeout", {31'd0, bus.cmd_ready}, 1);
    set_cmd(w, a, d, x);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!bus.rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 1);
  endtask

  task automatic wait_rsp(input string tag, input logic hit, input logic [N-1:0] addr);
    wait_valid(tag);
    chk({tag, "_hit"}, {31'd0, bus.rsp_hit}, {31'd0, hit});
    chk({tag, "_addr"}, {30'd0, bus.rsp_address}, {30'd0, addr});
    if (hit && exp_hits < HMAX) exp_hits++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, "_cnt"}, {30'd0, hit_count}, exp_hits);
  endtask

  typedef struct { logic [W-1:0] key; logic hit; logic [N-1:0] addr; } srch_t;

  initial begin
    srch_t     q [4];
    logic [5:0] wpat;
    logic      seen;

    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    set_cmd(1'b0, '0, '0, '0);

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rst_rsp_hit", {31'd0, bus.rsp_hit}, 0);
    chk("rst_rsp_addr", {30'd0, bus.rsp_address}, 0);
    chk("rst_hit_count", {30'd0, hit_count}, 0);
    chk("rst_tcam_data", {24'd0, bus.tcam_data}, 0);
    chk("rst_tcam_x", {24'd0, bus.tcam_data_x}, 0);
    chk("rst_wrb", {31'd0, bus.tcam_w_r_bar}, 0);
    chk("rst_waddr", {30'd0, bus.tcam_write_address}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Write addr 1 A5/0F, then wildcard-hitting search A3
    push(1'b1, 2'd1, 8'hA5, 8'h0F);
    chk("w1_wrb_k", {31'd0, bus.tcam_w_r_bar}, 0);
    @(posedge clk); #1;
    chk("w1_wrb_k1", {31'd0, bus.tcam_w_r_bar}, 1);
    chk("w1_waddr", {30'd0, bus.tcam_write_address}, 1);
    chk("w1_data", {24'd0, bus.tcam_data}, 32'hA5);
    chk("w1_x", {24'd0, bus.tcam_data_x}, 32'h0F);
    @(posedge clk); #1;
    chk("w1_wrb_k2", {31'd0, bus.tcam_w_r_bar}, 0);
    chk("w1_busy_k2", {31'd0, busy}, 1);
    @(posedge clk); #1;
    chk("w1_busy_k3", {31'd0, busy}, 0);

    push(1'b0, 2'd0, 8'hA3, 8'h00);
    @(posedge clk); #1;
    chk("s1_valid_k1", {31'd0, bus.rsp_valid}, 0);
    @(posedge clk); #1;
    chk("s1_valid_k2", {31'd0, bus.rsp_valid}, 1);
    wait_rsp("s1", 1'b1, 2'd1);

    // Back-to-back writes of identical data to addr 0 and 3
    push(1'b1, 2'd0, 8'h3C, 8'h00);
    push(1'b1, 2'd3, 8'h3C, 8'h00);
    for (int i = 5; i >= 0; i--) begin
      wpat[i] = bus.tcam_w_r_bar;
      @(posedge clk); #1;
    end
    chk("w2_wrb_pattern", {26'd0, wpat}, 32'b100100);
    wait_rsp_dummy: begin end
    push(1'b0, 2'd0, 8'h3C, 8'h00);
    wait_rsp("s2", 1'b1, 2'd3);

    // Miss
    push(1'b0, 2'd0, 8'hFF, 8'h00);
    wait_rsp("s3", 1'b0, 2'd0);

    // Backpressure: hold the response while filling the FIFO
    push(1'b0, 2'd0, 8'hA3, 8'h00);
    wait_valid("s4");
    q[0] = '{8'h3C, 1'b1, 2'd3};
    q[1] = '{8'hFF, 1'b0, 2'd0};
    q[2] = '{8'hA3, 1'b1, 2'd1};
    q[3] = '{8'h3C, 1'b1, 2'd3};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin set_cmd(1'b0, '0, q[i].key, 8'h00); bus.cmd_valid = 1'b1; end
      else bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("s4_hold", {29'd0, bus.rsp_valid, bus.rsp_hit, bus.rsp_address}, 32'b1101);
    end
    bus.cmd_valid = 1'b0;
    chk("fifo_full_ready", {31'd0, bus.cmd_ready}, 0);
    chk("fifo_full_busy", {31'd0, busy}, 1);
    wait_rsp("s4", 1'b1, 2'd1);
    for (int i = 0; i < 4; i++) wait_rsp($sformatf("drain%0d", i), q[i].hit, q[i].addr);
    chk("drain_sat", {30'd0, hit_count}, HMAX);

    // Reset during SEARCH with a second command queued
    push(1'b0, 2'd0, 8'h3C, 8'h00);
    set_cmd(1'b0, '0, 8'hA3, 8'h00);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("rs_pre_busy", {31'd0, busy}, 1);
    rst = 1'b1; #1;
    chk("rs_valid", {31'd0, bus.rsp_valid}, 0);
    chk("rs_busy", {31'd0, busy}, 0);
    chk("rs_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rs_cnt", {30'd0, hit_count}, 0);
    exp_hits = 0;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | bus.rsp_valid; end
    chk("rs_flushed", {31'd0, seen}, 0);
    chk("rs_idle", {31'd0, busy}, 0);
    push(1'b0, 2'd0, 8'hA3, 8'h00);
    wait_rsp("post_rst", 1'b1, 2'd1);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 2'd0, 8'h3C, 8'h00);
      wait_rsp($sformatf("sat%0d", i), 1'b1, 2'd3);
    end
    chk("sat_final", {30'd0, hit_count}, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
